// File: rtl/uart_cal_ctrl.sv
// uart_cal_ctrl: ASCII calculator command engine between a UART receiver and
// a UART transmitter. Parses "A op B" terminated by CR or '=', computes the
// unsigned result and streams it back as decimal ASCII followed by CR LF.
//
// Ports:
//   clk        system clock
//   n_rst      asynchronous active-low reset
//   rx_data    received byte, qualified by rx_valid
//   rx_valid   one-cycle strobe from the receiver
//   tx_data    byte to transmit, held stable between strobes
//   tx_valid   one-cycle strobe to the transmitter, TX_GAP cycles apart
//   busy       high from terminator accepted until the final LF gap expires
//   err        one-cycle pulse together with the 'E' of an ERR response
//   dbg_state  current FSM state (state_t encoding) for observation
//
// Handshake: rx_valid and tx_valid are single-cycle strobes with no ready
// signal in either direction. A byte offered while the engine is computing or
// transmitting is dropped; the transmitter is assumed to accept one byte per
// TX_GAP cycles.
module uart_cal_ctrl #(
  parameter int DW     = 16,
  parameter int TX_GAP = 104170,
  parameter int MAXDIG = 10
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       busy,
  output logic       err,
  output logic [2:0] dbg_state
);

  localparam int RW = 2 * DW;
  localparam int GW = $clog2(TX_GAP + 1);
  localparam int CW = $clog2(RW + 1);
  localparam int NW = $clog2(MAXDIG + 1);
  localparam int IW = $clog2(MAXDIG);

  typedef enum logic [2:0] {
    S_IDLE, S_OPA, S_OPB, S_DIV, S_CONV, S_SEND, S_GAP
  } state_t;

  // Which byte of the response goes out at the next strobe.
  typedef enum logic [2:0] {
    B_SIGN, B_DIG, B_CR, B_LF, B_E, B_R1, B_R2
  } byte_t;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  state_t          state_q, state_d;
  byte_t           snd_q, snd_d;
  logic [DW-1:0]   a_q, a_d, b_q, b_d;
  logic [1:0]      op_q, op_d;
  logic            bad_q, bad_d, bdig_q, bdig_d, neg_q, neg_d;
  logic [RW-1:0]   res_q, res_d;
  logic [DW:0]     rem_q, rem_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NW-1:0]   ndig_q, ndig_d;
  logic [IW-1:0]   dptr_q, dptr_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [3:0]      dig_q [MAXDIG];
  logic [3:0]      dig_d [MAXDIG];
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_valid_q, tx_valid_d, busy_q, busy_d, err_q, err_d;

  logic [DW+3:0]   acc_w;
  logic [DW-1:0]   acc_src;
  logic [DW:0]     rem_sh, dvsr, rem_nx;
  logic            q_bit;
  logic [RW-1:0]   quo_nx;

  always_comb begin
    // Operand accumulation: whichever operand is being parsed, times ten plus
    // the new digit, kept wide so overflow is visible in the top bits.
    acc_src = (state_q == S_OPB) ? b_q : a_q;
    acc_w   = {4'b0, acc_src} * (DW+4)'(10) + (DW+4)'(rx_data[3:0]);

    // Shared restoring-division step. In DIV the low DW bits of res_q hold
    // the dividend/quotient and b_q is the divisor; in CONV the whole res_q
    // is divided by ten. The quotient bit shifts into the LSB in place.
    if (state_q == S_DIV) begin
      rem_sh = {rem_q[DW-1:0], res_q[DW-1]};
      dvsr   = {1'b0, b_q};
    end else begin
      rem_sh = {rem_q[DW-1:0], res_q[RW-1]};
      dvsr   = (DW+1)'(10);
    end
    q_bit  = (rem_sh >= dvsr);
    rem_nx = q_bit ? (rem_sh - dvsr) : rem_sh;
    quo_nx = {res_q[RW-2:0], q_bit};

    state_d    = state_q;
    snd_d      = snd_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    bad_d      = bad_q;
    bdig_d     = bdig_q;
    neg_d      = neg_q;
    res_d      = res_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    ndig_d     = ndig_q;
    dptr_d     = dptr_q;
    gap_d      = gap_q;
    dig_d      = dig_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      S_IDLE, S_OPA, S_OPB: begin
        if (rx_valid) begin
          if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
            if (state_q == S_OPB) begin
              b_d    = acc_w[DW-1:0];
              bdig_d = 1'b1;
            end else begin
              a_d     = acc_w[DW-1:0];
              state_d = S_OPA;
            end
            if (|acc_w[DW+3:DW]) bad_d = 1'b1;
          end else if (rx_data == 8'h20 || rx_data == 8'h0A) begin
            // whitespace and LF carry no meaning
          end else if (rx_data == 8'h2B || rx_data == 8'h2D ||
                       rx_data == 8'h2A || rx_data == 8'h2F) begin
            if (state_q == S_OPA) begin
              case (rx_data)
                8'h2B:   op_d = OP_ADD;
                8'h2D:   op_d = OP_SUB;
                8'h2A:   op_d = OP_MUL;
                default: op_d = OP_DIV;
              endcase
              state_d = S_OPB;
            end else begin
              bad_d = 1'b1;
            end
          end else if (rx_data == 8'h0D || rx_data == 8'h3D) begin
            // Any terminator ends the command; only "A op B" is well formed.
            if (!(state_q == S_OPB && bdig_q)) bad_d = 1'b1;
            state_d = S_DIV;
            cnt_d   = '0;
            rem_d   = '0;
            res_d   = RW'(a_q);
            neg_d   = 1'b0;
          end else begin
            bad_d = 1'b1;
          end
        end
      end

      S_DIV: begin
        if (bad_q || (op_q == OP_DIV && b_q == '0)) begin
          bad_d   = 1'b1;
          state_d = S_SEND;
          snd_d   = B_E;
          gap_d   = '0;
        end else if (op_q == OP_DIV) begin
          res_d[DW-1:0] = quo_nx[DW-1:0];
          rem_d         = rem_nx;
          cnt_d         = cnt_q + 1'b1;
          if (cnt_q == CW'(DW-1)) begin
            state_d = S_CONV;
            cnt_d   = '0;
            rem_d   = '0;
            ndig_d  = '0;
          end
        end else begin
          case (op_q)
            OP_ADD: res_d = RW'({1'b0, a_q} + {1'b0, b_q});
            OP_SUB: begin
              res_d = (a_q >= b_q) ? RW'(a_q - b_q) : RW'(b_q - a_q);
              neg_d = (a_q < b_q);
            end
            default: res_d = RW'(a_q) * RW'(b_q);
          endcase
          state_d = S_CONV;
          cnt_d   = '0;
          rem_d   = '0;
          ndig_d  = '0;
        end
      end

      S_CONV: begin
        res_d = quo_nx;
        rem_d = rem_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(RW-1)) begin
          // One digit done: remainder is the next digit, LSB first.
          if (ndig_q < NW'(MAXDIG)) dig_d[IW'(ndig_q)] = rem_nx[3:0];
          ndig_d = ndig_q + 1'b1;
          cnt_d  = '0;
          rem_d  = '0;
          if (quo_nx == '0) begin
            state_d = S_SEND;
            gap_d   = '0;
            dptr_d  = IW'(ndig_q);
            snd_d   = neg_q ? B_SIGN : B_DIG;
          end
        end
      end

      S_SEND: begin
        if (gap_q == '0) begin
          tx_valid_d = 1'b1;
          gap_d      = GW'(TX_GAP - 1);
          case (snd_q)
            B_SIGN: begin tx_data_d = 8'h2D; snd_d = B_DIG; end
            B_DIG: begin
              tx_data_d = 8'h30 + {4'h0, dig_q[dptr_q]};
              if (dptr_q == '0) snd_d = B_CR;
              else              dptr_d = dptr_q - 1'b1;
            end
            B_CR:   begin tx_data_d = 8'h0D; snd_d = B_LF; end
            B_LF:   begin tx_data_d = 8'h0A; state_d = S_GAP; end
            B_E:    begin tx_data_d = 8'h45; err_d = 1'b1; snd_d = B_R1; end
            B_R1:   begin tx_data_d = 8'h52; snd_d = B_R2; end
            default: begin tx_data_d = 8'h52; snd_d = B_CR; end
          endcase
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end

      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_IDLE;
          a_d     = '0;
          b_d     = '0;
          op_d    = OP_ADD;
          bad_d   = 1'b0;
          bdig_d  = 1'b0;
          neg_d   = 1'b0;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_DIV) || (state_d == S_CONV) ||
             (state_d == S_SEND) || (state_d == S_GAP);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= S_IDLE;
      snd_q      <= B_DIG;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= OP_ADD;
      bad_q      <= 1'b0;
      bdig_q     <= 1'b0;
      neg_q      <= 1'b0;
      res_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      ndig_q     <= '0;
      dptr_q     <= '0;
      gap_q      <= '0;
      for (int i = 0; i < MAXDIG; i++) dig_q[i] <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      snd_q      <= snd_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      bad_q      <= bad_d;
      bdig_q     <= bdig_d;
      neg_q      <= neg_d;
      res_q      <= res_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      ndig_q     <= ndig_d;
      dptr_q     <= dptr_d;
      gap_q      <= gap_d;
      dig_q      <= dig_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_cal_ctrl.sv
// Testbench for uart_cal_ctrl: drives ASCII commands, queues the expected
// response bytes and checks every tx strobe against the queue, plus pacing,
// busy/err behaviour, dropped bytes, latency and reset.
module tb_uart_cal_ctrl;

  localparam int DW     = 16;
  localparam int TX_GAP = 20;
  localparam int MAXDIG = 10;
  localparam int LAT_MAX = DW + MAXDIG * (2 * DW + 1) + 4;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid, busy, err;
  logic [2:0] dbg_state;

  logic [7:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_cyc = 0;
  int err_cnt = 0;
  logic have_prev = 1'b0;
  logic [7:0] prev_b = 8'h00;

  uart_cal_ctrl #(.DW(DW), .TX_GAP(TX_GAP), .MAXDIG(MAXDIG)) dut (
    .clk(clk), .n_rst(n_rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .busy(busy), .err(err),
    .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // One cycle step: wait for the falling edge, then score any tx strobe.
  task automatic tick();
    logic [7:0] e;
    @(negedge clk);
    if (!n_rst) begin
      have_prev = 1'b0;
    end else begin
      if (err) begin
        err_cnt++;
        total++;
        if (!(tx_valid === 1'b1 && tx_data === 8'h45)) begin
          bad++;
          $display("FAIL err_pulse: tx_valid=%b tx_data=%h, need 1 and 45", tx_valid, tx_data);
        end
      end
      if (tx_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_byte: got %h with nothing expected", tx_data);
        end else begin
          e = exp_q.pop_front();
          if (tx_data !== e) begin
            bad++;
            $display("FAIL tx_byte: got %h, need %h", tx_data, e);
          end
        end
        total++;
        if (busy !== 1'b1) begin
          bad++;
          $display("FAIL busy_during_tx: busy=%b, need 1", busy);
        end
        if (have_prev && prev_b != 8'h0A) begin
          total++;
          if (cyc - last_cyc != TX_GAP) begin
            bad++;
            $display("FAIL tx_spacing: %0d cycles, need %0d", cyc - last_cyc, TX_GAP);
          end
        end
        have_prev = 1'b1;
        prev_b    = tx_data;
        last_cyc  = cyc;
      end
    end
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic push_exp(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && busy === 1'b0) && n < 5000) begin
      tick();
      n++;
    end
    total++;
    if (n >= 5000) begin
      bad++;
      $display("FAIL %s_timeout: %0d bytes outstanding busy=%b, need 0 and 0", name, exp_q.size(), busy);
      exp_q.delete();
    end
  endtask

  task automatic wait_strobe(input string name);
    int n;
    n = 0;
    while (tx_valid !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) begin
      total++;
      bad++;
      $display("FAIL %s_no_strobe: waited %0d cycles", name, n);
    end
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 || err !== 1'b0 || dbg_state !== 3'd0) begin
      bad++;
      $display("FAIL reset_outputs: v=%b d=%h busy=%b err=%b st=%0d, need 0 00 0 0 0", tx_valid, tx_data, busy, err, dbg_state);
    end
    repeat (3) tick();
    n_rst = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_add();
    push_exp("46");
    send_str("12+34");
    send_byte(8'h0D);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_after_term: busy=%b, need 1", busy);
    end
    wait_idle("add");
    total++;
    if (dbg_state !== 3'd0) begin
      bad++;
      $display("FAIL idle_after_add: state=%0d, need 0", dbg_state);
    end
  endtask

  task automatic test_sub();
    push_exp("-4");
    send_str("5 - 9=");
    wait_idle("sub");
  endtask

  task automatic test_mul_latency();
    int lat;
    push_exp("4294836225");
    send_str("65535*65535");
    rx_data  = 8'h0D;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    lat = 1;
    tick();
    while (tx_valid !== 1'b1 && lat < 2 * LAT_MAX) begin
      tick();
      lat++;
    end
    total++;
    if (lat > LAT_MAX) begin
      bad++;
      $display("FAIL first_tx_latency: %0d cycles, need <= %0d", lat, LAT_MAX);
    end
    wait_idle("mul");
  endtask

  task automatic test_errors();
    int e0;
    e0 = err_cnt;
    push_exp("ERR");
    send_str("7/0"); send_byte(8'h0D);
    wait_idle("div0");
    push_exp("ERR");
    send_str("70000+1"); send_byte(8'h0D);
    wait_idle("ovf");
    push_exp("ERR");
    send_str("+3"); send_byte(8'h0D);
    wait_idle("leadop");
    total++;
    if (err_cnt - e0 != 3) begin
      bad++;
      $display("FAIL err_count: %0d pulses, need 3", err_cnt - e0);
    end
  endtask

  task automatic test_zero_div();
    push_exp("0");
    send_str("0+0"); send_byte(8'h0D);
    wait_idle("zero");
    push_exp("14");
    send_str("100/7"); send_byte(8'h0D);
    wait_idle("div");
  endtask

  task automatic test_drop_during_send();
    push_exp("64");
    send_str("8*8"); send_byte(8'h0D);
    wait_strobe("drop");
    send_str("9+9"); send_byte(8'h0D);
    wait_idle("drop");
    push_exp("2");
    send_str("1+1"); send_byte(8'h0D);
    wait_idle("after_drop");
  endtask

  task automatic test_gap_edge();
    int n;
    push_exp("1");
    send_str("1*1"); send_byte(8'h0D);
    n = 0;
    while (!(tx_valid === 1'b1 && tx_data === 8'h0A) && n < 2000) begin
      tick();
      n++;
    end
    repeat (TX_GAP - 1) tick();
    send_byte(8'h35);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL gap_end_busy: busy=%b, need 0", busy);
    end
    push_exp("7");
    send_str("3+4"); send_byte(8'h0D);
    wait_idle("gap_edge");
  endtask

  task automatic test_reset_mid_send();
    push_exp("579");
    send_str("123+456"); send_byte(8'h0D);
    wait_strobe("rst_mid");
    repeat (5) tick();
    n_rst = 1'b0;
    #1;
    total++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || tx_data !== 8'h00 || dbg_state !== 3'd0) begin
      bad++;
      $display("FAIL reset_mid_send: v=%b busy=%b d=%h st=%0d, need 0 0 00 0", tx_valid, busy, tx_data, dbg_state);
    end
    exp_q.delete();
    repeat (3) tick();
    n_rst = 1'b1;
    repeat (3 * TX_GAP) tick();
    push_exp("6");
    send_str("2*3"); send_byte(8'h0D);
    wait_idle("after_reset");
  endtask

  task automatic test_random();
    int a, b, op;
    string s, r;
    for (int k = 0; k < 6; k++) begin
      op = $urandom_range(0, 3);
      a  = $urandom_range(0, 65535);
      b  = (op == 3) ? $urandom_range(1, 65535) : $urandom_range(0, 65535);
      case (op)
        0: begin s = $sformatf("%0d+%0d", a, b); r = $sformatf("%0d", a + b); end
        1: begin
          s = $sformatf("%0d-%0d", a, b);
          r = (a >= b) ? $sformatf("%0d", a - b) : $sformatf("-%0d", b - a);
        end
        2: begin s = $sformatf("%0d*%0d", a, b); r = $sformatf("%0d", longint'(a) * longint'(b)); end
        default: begin s = $sformatf("%0d/%0d", a, b); r = $sformatf("%0d", a / b); end
      endcase
      push_exp(r);
      send_str(s);
      send_byte(8'h0D);
      wait_idle("random");
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul_latency();
    test_errors();
    test_zero_div();
    test_drop_during_send();
    test_gap_edge();
    test_reset_mid_send();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_cal_ctrl.md
Name: uart_cal_ctrl

Overview:
- Calculator command engine sitting directly downstream of the uart receive path and upstream of the uart transmit path.
- Consumes ASCII bytes (rx_data/rx_valid) forming "A op B" terminated by CR or '='.
- Computes the unsigned integer result and streams it back as ASCII decimal followed by CR LF (tx_data/tx_valid).
- Paces transmit bytes with a fixed cycle gap, because the transmitter exposes no ready signal.

Parameters:
- DW, 16, operand width in bits; each operand is unsigned with range 0..2^DW-1.
- TX_GAP, 104170, clock cycles between successive tx_valid pulses; must be at least one full UART frame (10 bit times).
- MAXDIG, 10, decimal digit buffer depth; must hold 2*DW-bit products.

Ports:
- clk  input  1  system clock
- n_rst  input  1  asynchronous active-low reset
- rx_data  input  8  received byte
- rx_valid  input  1  one-cycle strobe, rx_data valid
- tx_data  output  8  byte to transmit; held stable between strobes
- tx_valid  output  1  one-cycle strobe to transmitter
- busy  output  1  high from terminator accepted until final LF gap expires
- err  output  1  one-cycle pulse when an ERR response is started

Behaviour:
- Reset (asynchronous, n_rst low):
  - state IDLE; A=B=0; all flags clear.
  - tx_data=8'h00, tx_valid=0, busy=0, err=0.
  - Reset mid-operation aborts any calculation or transmission immediately; no partial bytes are resent after release.
- States: IDLE, OPA, OPB, DIV, CONV, SEND, GAP.
- Parsing (rx_valid high, states IDLE/OPA/OPB only):
  - Digit '0'-'9': operand = operand*10 + digit; enters OPA from IDLE.
  - Overflow past 2^DW-1 sets the sticky bad flag; accumulation continues, masked.
  - Space (0x20) is ignored in any parse state.
  - '+', '-', '*', '/' in OPA latches op and goes to OPB. An operator in IDLE or OPB sets bad.
  - CR (0x0D) or '=' in OPB with at least one B digit starts the calculation.
  - CR or '=' elsewhere also ends the command, with bad set.
  - LF (0x0A) is ignored.
  - Any other byte sets bad.
- rx_valid outside IDLE/OPA/OPB (DIV, CONV, SEND, GAP): the byte is dropped silently; no buffering.
- Calculation, starting in the cycle after the terminator:
  - '+': 17-bit sum.
  - '-': if A>=B, A-B; else magnitude B-A with a negative-sign flag.
  - '*': 2*DW-bit product, single cycle, combinational multiply allowed.
  - '/': quotient A/B via restoring divider in DIV, DW cycles.
  - B==0 for '/' sets bad.
- Result conversion (CONV):
  - Repeated divide-by-10 (shift/subtract, 2*DW cycles per digit).
  - Remainders are pushed into the digit buffer until the quotient is 0.
  - A zero value yields the single digit "0". Leading zeros are never sent.
- Transmit sequence:
  - If bad: "ERR" CR LF, with err pulsed in the cycle the 'E' is strobed.
  - Else: optional '-', digits MSB first, then CR, then LF.
- Transmit pacing:
  - tx_valid is high for exactly 1 cycle per byte.
  - Strobes are exactly TX_GAP cycles apart.
  - After LF, GAP runs TX_GAP cycles, then busy drops and the state returns to IDLE with A, B, op and bad cleared.
- Latency: first tx_valid occurs no later than DW + MAXDIG*(2*DW+1) + 4 cycles after the terminator strobe.
- Simultaneous events: if rx_valid coincides with the last GAP cycle, the byte is dropped; parsing resumes on the next cycle.

Test Plan:
- Bytes "12+34\r" -> tx sequence 0x34 0x36 0x0D 0x0A ("46\r\n"); busy high throughout; strobes spaced TX_GAP.
- "5 - 9=" -> "-4\r\n"; space ignored; sign byte 0x2D sent first.
- "65535*65535\r" -> "4294836225\r\n" (10 digits, full buffer).
- "7/0\r" -> "ERR\r\n" with err pulse; "70000+1\r" -> "ERR\r\n" (overflow); "+3\r" -> "ERR\r\n".
- "0+0\r" -> "0\r\n"; "100/7\r" -> "14\r\n"; bytes "9+9\r" injected during SEND are dropped and the output stays unchanged.
- Assert n_rst low mid-SEND -> tx_valid=0 and busy=0 immediately; after release, "2*3\r" -> "6\r\n".
